pcs_block_lock: RTL
===================

PCS_BLOCK_LOCK -- requirements
Module: pcs_block_lock

Interface
REQ-001 SHALL have parameter SH_CNT_MAX, default 64: sync headers per test window.
REQ-002 SHALL have parameter SH_INVLD_MAX, default 16: invalid headers per window that force lock loss; legal range 1 to SH_CNT_MAX-1.
REQ-003 SHALL have parameter SLIP_WAIT, default 4: cycles to wait after a slip before hunting resumes; minimum 1.
REQ-004 SHALL have port CLK, input, 1 bit: single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port hdr_vld, input, 1 bit: strobe marking a new 66-bit block on this cycle.
REQ-007 SHALL have port hdr, input, 2 bits: sync header of that block, sampled only when hdr_vld=1.
REQ-008 SHALL have port slip, output, 1 bit: one-cycle pulse telling the gearbox to shift block alignment by one bit.
REQ-009 SHALL have port block_lock, output, 1 bit: block alignment acquired.
REQ-010 SHALL have port data_valid, output, 1 bit: the descrambler output for this block is trustworthy.
REQ-011 SHALL have port lock_loss_cnt, output, 8 bits: count of LOCKED-to-unlocked transitions, saturating at 255.

Function
REQ-012 Valid header SHALL mean hdr==2'b01 or hdr==2'b10; 2'b00 and 2'b11 SHALL be invalid.
REQ-013 The FSM SHALL have exactly these states: RESET_CNT, HUNT, SLIP, LOCKED.
REQ-014 RESET_CNT SHALL clear sh_cnt and sh_invld_cnt and go to HUNT on the next cycle; a hdr_vld in this cycle SHALL be ignored.
REQ-015 In HUNT, each hdr_vld SHALL increment sh_cnt.
REQ-016 In HUNT, an invalid header SHALL cause a transition to SLIP.
REQ-017 In HUNT, the SH_CNT_MAX-th consecutive valid header SHALL cause a transition to LOCKED, clear both counters, and set block_lock=1 on the following cycle.
REQ-018 On entry to SLIP, slip SHALL pulse high for exactly one cycle.
REQ-019 SLIP SHALL then ignore hdr_vld for SLIP_WAIT cycles, counting from the cycle after the slip pulse, and then go to RESET_CNT.
REQ-020 In LOCKED, each hdr_vld SHALL increment sh_cnt, and each invalid header SHALL also increment sh_invld_cnt.
REQ-021 In LOCKED, when sh_invld_cnt reaches SH_INVLD_MAX, the state SHALL go to SLIP, block_lock SHALL clear on the next cycle, and lock_loss_cnt SHALL increment.
REQ-022 In LOCKED, when sh_cnt reaches SH_CNT_MAX with sh_invld_cnt below SH_INVLD_MAX, both counters SHALL clear and the state SHALL remain LOCKED.
REQ-023 If the window-ending header is also the SH_INVLD_MAX-th invalid header, lock loss SHALL win.
REQ-024 Descrambler flush: the first hdr_vld after block_lock rises SHALL NOT assert data_valid, because the 58-bit feed-forward state is stale.
REQ-025 After that flush block, data_valid SHALL be a registered copy of hdr_vld, one cycle later, while block_lock=1.
REQ-026 data_valid SHALL be 0 whenever block_lock=0.
REQ-027 Re-acquiring lock SHALL repeat the flush.
REQ-028 slip, block_lock and data_valid SHALL be driven directly from flops, with no combinational path from any input.
REQ-029 lock_loss_cnt SHALL hold at 255 and never wrap.

Reset
REQ-030 rst SHALL take priority over every other event in the same cycle.
REQ-031 While rst=1, the FSM SHALL be in RESET_CNT, all counters 0, slip=0, block_lock=0, data_valid=0, lock_loss_cnt=0.
REQ-032 Reset asserted in any state, including mid-SLIP wait or LOCKED, SHALL abort that state without issuing a slip pulse.
REQ-033 Hunting SHALL restart from RESET_CNT on the first cycle after rst falls.

Structure
REQ-034 Package pcs_pkg SHALL hold the FSM state enum and the constants SH_DATA=2'b01 and SH_CTRL=2'b10.
REQ-035 This block SHALL contain no sub-module; it sits beside Descrambler_64bit in the receive top level.
REQ-036 Counter widths SHALL be $clog2(SH_CNT_MAX+1) and $clog2(SLIP_WAIT+1).

Verification
REQ-037 64 hdr_vld with hdr=01 -> block_lock=1 one cycle after the 64th; data_valid stays 0 for the 65th block and rises from the 66th.
REQ-038 Valid headers interrupted by hdr=11 at block 30 of the hunt -> single slip pulse; hdr_vld ignored for 4 cycles; hunt restarts; lock needs 64 more valid headers.
REQ-039 Locked, 15 invalid headers in a 64-header window -> lock held, counters clear at window end; then 16 invalid in the next window -> block_lock=0, slip pulse, lock_loss_cnt=1.
REQ-040 Locked window whose 64th header is the 16th invalid -> lock lost, not window reset.
REQ-041 rst=1 asserted during the SLIP wait and while LOCKED -> all outputs 0 on the next cycle, no slip pulse; lock re-acquired after 64 valid headers.
REQ-042 256 forced lock losses -> lock_loss_cnt=255 and stays at 255.

Source files
------------

// File: rtl/pcs_pkg.sv
// Shared definitions for the 64b/66b receive PCS: lock FSM states and sync-header codes.
// Used by the block-lock FSM and by the test bench.
package pcs_pkg;

    typedef enum logic [1:0] {
        RESET_CNT,
        HUNT,
        SLIP,
        LOCKED
    } lock_state_t;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    // Only 01 and 10 carry a real 64b/66b block; 00 and 11 indicate misalignment.
    function automatic logic hdr_is_valid(input logic [1:0] h);
        return (h == SH_DATA) || (h == SH_CTRL);
    endfunction

endpackage

// File: rtl/pcs_block_lock.sv
// 64b/66b block-lock FSM: hunts for sync-header alignment, requests gearbox slips,
// and qualifies descrambler output once lock is held and the descrambler is flushed.
module pcs_block_lock
    import pcs_pkg::*;
#(
    parameter int SH_CNT_MAX   = 64,
    parameter int SH_INVLD_MAX = 16,
    parameter int SLIP_WAIT    = 4
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       hdr_vld,
    input  logic [1:0] hdr,
    output logic       slip,
    output logic       block_lock,
    output logic       data_valid,
    output logic [7:0] lock_loss_cnt
);

    localparam int CNT_W  = $clog2(SH_CNT_MAX + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(SH_CNT_MAX);
    localparam logic [CNT_W-1:0]  INVLD_LAST = CNT_W'(SH_INVLD_MAX);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(SLIP_WAIT);

    lock_state_t       state, state_nxt;
    logic [CNT_W-1:0]  sh_cnt, sh_cnt_nxt;
    logic [CNT_W-1:0]  sh_invld_cnt, sh_invld_cnt_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              hdr_ok;
    logic              flushed;

    assign hdr_ok = hdr_is_valid(hdr);

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_nxt        = state;
        sh_cnt_nxt       = sh_cnt;
        sh_invld_cnt_nxt = sh_invld_cnt;
        wait_cnt_nxt     = wait_cnt;

        unique case (state)
            RESET_CNT: begin
                sh_cnt_nxt       = '0;
                sh_invld_cnt_nxt = '0;
                state_nxt        = HUNT;
            end

            HUNT: begin
                if (hdr_vld) begin
                    sh_cnt_nxt = sh_cnt + 1'b1;
                    if (!hdr_ok) begin
                        state_nxt    = SLIP;
                        wait_cnt_nxt = '0;
                    end else if (sh_cnt_nxt == CNT_LAST) begin
                        state_nxt        = LOCKED;
                        sh_cnt_nxt       = '0;
                        sh_invld_cnt_nxt = '0;
                    end
                end
            end

            // wait_cnt is 0 during the slip-pulse cycle, then counts SLIP_WAIT quiet cycles.
            SLIP: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_nxt = RESET_CNT;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end

            LOCKED: begin
                if (hdr_vld) begin
                    sh_cnt_nxt       = sh_cnt + 1'b1;
                    sh_invld_cnt_nxt = sh_invld_cnt + CNT_W'(!hdr_ok);
                    // Lock loss is tested first so it wins on the window-ending header.
                    if (sh_invld_cnt_nxt == INVLD_LAST) begin
                        state_nxt    = SLIP;
                        wait_cnt_nxt = '0;
                    end else if (sh_cnt_nxt == CNT_LAST) begin
                        sh_cnt_nxt       = '0;
                        sh_invld_cnt_nxt = '0;
                    end
                end
            end

            default: state_nxt = RESET_CNT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state        <= RESET_CNT;
            sh_cnt       <= '0;
            sh_invld_cnt <= '0;
            wait_cnt     <= '0;
        end else begin
            state        <= state_nxt;
            sh_cnt       <= sh_cnt_nxt;
            sh_invld_cnt <= sh_invld_cnt_nxt;
            wait_cnt     <= wait_cnt_nxt;
        end
    end

    // Outputs come straight from flops, computed from the next state.
    always_ff @(posedge CLK) begin
        if (rst) begin
            slip          <= 1'b0;
            block_lock    <= 1'b0;
            data_valid    <= 1'b0;
            flushed       <= 1'b0;
            lock_loss_cnt <= '0;
        end else begin
            slip       <= (state != SLIP) && (state_nxt == SLIP);
            block_lock <= (state_nxt == LOCKED);
            data_valid <= hdr_vld && flushed && (state_nxt == LOCKED);

            // The first block after lock only primes the descrambler's feed-forward state.
            if (state_nxt != LOCKED) begin
                flushed <= 1'b0;
            end else if ((state == LOCKED) && hdr_vld) begin
                flushed <= 1'b1;
            end

            if ((state == LOCKED) && (state_nxt == SLIP) && (lock_loss_cnt != 8'hFF)) begin
                lock_loss_cnt <= lock_loss_cnt + 8'd1;
            end
        end
    end

endmodule
